// File: rtl/card_selector.sv
// Memory-game player input: debounced next/select buttons, cursor over the
// 16-card grid, and a latch for up to two selected card indices.
module card_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync2_q, stable_q, stable_dly_q, press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            // Registered falling edge of the debounced level; release is ignored.
            press_q      <= stable_dly_q & ~stable_q;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;
endmodule

module card_selector #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             btn_next,
    input  logic             btn_sel,
    input  logic [15:0][4:0] arr_cartas,
    output logic [3:0]       cursor,
    output logic [3:0]       sel_idx0,
    output logic [3:0]       sel_idx1,
    output logic [1:0]       cartas_sel,
    output logic             carta_elegida
);
    logic [1:0] btn_raw, press;
    assign btn_raw = {btn_sel, btn_next};

    for (genvar g = 0; g < 2; g++) begin : g_deb
        card_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i  (clk),
            .rst_ni (rst),
            .btn_i  (btn_raw[g]),
            .press_o(press[g])
        );
    end

    logic [3:0] cursor_q, cursor_d, idx0_q, idx0_d, idx1_q, idx1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       elegida_q, elegida_d;
    logic [3:0] nxt_idx, probe;
    logic       nxt_found, accept, unused_lo;

    // First unmatched card after the cursor, scanning with wrap-around.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = cursor_q;
        probe     = '0;
        for (int k = 1; k < 16; k++) begin
            probe = cursor_q + 4'(k);
            if (!nxt_found && !arr_cartas[probe][4]) begin
                nxt_found = 1'b1;
                nxt_idx   = probe;
            end
        end
    end

    always_comb begin
        unused_lo = 1'b0;
        for (int i = 0; i < 16; i++) unused_lo = unused_lo ^ (^arr_cartas[i][3:0]);
    end

    assign accept = enable && press[1] && !arr_cartas[cursor_q][4] && (cnt_q < 2'd2)
                    && !((cnt_q == 2'd1) && (cursor_q == idx0_q));

    always_comb begin
        cursor_d  = cursor_q;
        idx0_d    = idx0_q;
        idx1_d    = idx1_q;
        cnt_d     = cnt_q;
        elegida_d = 1'b0;
        if (enable && press[0]) cursor_d = nxt_idx;
        // clear wins over a select landing in the same cycle
        if (clear) begin
            cnt_d  = '0;
            idx0_d = '0;
            idx1_d = '0;
        end else if (accept) begin
            if (cnt_q == 2'd0) idx0_d = cursor_q;
            else               idx1_d = cursor_q;
            cnt_d     = cnt_q + 2'd1;
            elegida_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor_q  <= '0;
            idx0_q    <= '0;
            idx1_q    <= '0;
            cnt_q     <= '0;
            elegida_q <= 1'b0;
        end else begin
            cursor_q  <= cursor_d;
            idx0_q    <= idx0_d;
            idx1_q    <= idx1_d;
            cnt_q     <= cnt_d;
            elegida_q <= elegida_d;
        end
    end

    assign cursor        = cursor_q;
    assign sel_idx0      = idx0_q;
    assign sel_idx1      = idx1_q;
    assign cartas_sel    = cnt_q;
    assign carta_elegida = elegida_q;
endmodule
